// File: rtl/tb_multi_eoc_sequencer.sv
// Boot/completion sequencer: holds the core in reset, boots it after preload,
// then gathers per-hart EOC/pass-fail results under an optional watchdog.
module tb_multi_eoc_sequencer #(
    parameter int               N_CH        = 3,
    parameter logic [N_CH-1:0]  CH_EN       = {N_CH{1'b1}},
    parameter int               RST_CYCLES  = 16,
    parameter int               BOOT_CYCLES = 8,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] TIMEOUT     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [N_CH-1:0]  eoc_i,
    input  logic [N_CH-1:0]  err_i,
    output logic             core_rst_n_o,
    output logic             fetch_enable_o,
    output logic             done_o,
    output logic [1:0]       exit_code_o,
    output logic [N_CH-1:0]  fail_mask_o,
    output logic [N_CH-1:0]  done_mask_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [2:0] {RESET_HOLD, WAIT_START, BOOT_DELAY, RUN, DONE} state_t;

    localparam logic [31:0]      RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0]      BOOT_LAST = 32'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST   = TIMEOUT - CNT_W'(1);

    state_t            state_reg, state_next;
    logic [31:0]       phase_reg, phase_next;
    logic              core_rst_n_reg, core_rst_n_next;
    logic              fetch_en_reg, fetch_en_next;
    logic              done_reg, done_next;
    logic [1:0]        exit_code_reg, exit_code_next;
    logic [N_CH-1:0]   fail_mask_reg, fail_mask_next;
    logic [N_CH-1:0]   done_mask_reg, done_mask_next;
    logic              timeout_reg, timeout_next;
    logic [CNT_W-1:0]  cycle_count_reg, cycle_count_next;
    logic [N_CH-1:0]   eoc_q_reg, eoc_q_next;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   next_fail;
    logic [N_CH-1:0]   next_mask;

    // Only the first enabled rising edge of a channel is recorded; later
    // edges on a finished channel cannot overwrite its pass/fail result.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rise[gi]      = eoc_i[gi] & ~eoc_q_reg[gi] & CH_EN[gi] & ~done_mask_reg[gi];
            assign next_fail[gi] = rise[gi] ? err_i[gi] : fail_mask_reg[gi];
        end
    endgenerate

    assign next_mask = done_mask_reg | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RESET_HOLD;
            phase_reg       <= '0;
            core_rst_n_reg  <= 1'b0;
            fetch_en_reg    <= 1'b0;
            done_reg        <= 1'b0;
            exit_code_reg   <= 2'b11;
            fail_mask_reg   <= '0;
            done_mask_reg   <= '0;
            timeout_reg     <= 1'b0;
            cycle_count_reg <= '0;
            eoc_q_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            core_rst_n_reg  <= core_rst_n_next;
            fetch_en_reg    <= fetch_en_next;
            done_reg        <= done_next;
            exit_code_reg   <= exit_code_next;
            fail_mask_reg   <= fail_mask_next;
            done_mask_reg   <= done_mask_next;
            timeout_reg     <= timeout_next;
            cycle_count_reg <= cycle_count_next;
            eoc_q_reg       <= eoc_q_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        core_rst_n_next  = core_rst_n_reg;
        fetch_en_next    = fetch_en_reg;
        done_next        = done_reg;
        exit_code_next   = exit_code_reg;
        fail_mask_next   = fail_mask_reg;
        done_mask_next   = done_mask_reg;
        timeout_next     = timeout_reg;
        cycle_count_next = cycle_count_reg;
        eoc_q_next       = eoc_q_reg;

        case (state_reg)
            RESET_HOLD: begin
                if (phase_reg == RST_LAST) begin
                    core_rst_n_next = 1'b1;
                    phase_next      = '0;
                    state_next      = WAIT_START;
                end else begin
                    phase_next = phase_reg + 32'd1;
                end
            end
            WAIT_START: begin
                if (start_i) begin
                    phase_next = '0;
                    state_next = BOOT_DELAY;
                end
            end
            BOOT_DELAY: begin
                if (phase_reg == BOOT_LAST) begin
                    fetch_en_next  = 1'b1;
                    phase_next     = '0;
                    eoc_q_next     = '0;
                    done_mask_next = ~CH_EN;
                    state_next     = RUN;
                end else begin
                    phase_next = phase_reg + 32'd1;
                end
            end
            RUN: begin
                eoc_q_next     = eoc_i;
                done_mask_next = next_mask;
                fail_mask_next = next_fail;
                if (cycle_count_reg != '1) begin
                    cycle_count_next = cycle_count_reg + CNT_W'(1);
                end
                // Completion takes priority over a watchdog expiring on the same edge.
                if (&next_mask) begin
                    done_next      = 1'b1;
                    fetch_en_next  = 1'b0;
                    exit_code_next = (|next_fail) ? 2'b01 : 2'b00;
                    state_next     = DONE;
                end else if ((TIMEOUT != '0) && (cycle_count_reg == WD_LAST)) begin
                    done_next      = 1'b1;
                    fetch_en_next  = 1'b0;
                    timeout_next   = 1'b1;
                    exit_code_next = 2'b11;
                    state_next     = DONE;
                end
            end
            DONE: begin
            end
            default: state_next = RESET_HOLD;
        endcase
    end

    assign core_rst_n_o   = core_rst_n_reg;
    assign fetch_enable_o = fetch_en_reg;
    assign done_o         = done_reg;
    assign exit_code_o    = exit_code_reg;
    assign fail_mask_o    = fail_mask_reg;
    assign done_mask_o    = done_mask_reg;
    assign timeout_o      = timeout_reg;
    assign cycle_count_o  = cycle_count_reg;

endmodule
